// File: rtl/axis_sigen_pkg.sv
// Shared definitions for the AXI-stream packet signal generator.
//   state_t     : controller FSM encoding
//   beat_desc_t : per-beat descriptor handed to the beat formatter
//   *_LSB       : tuser field offsets (byte length, source port, destination port)
package axis_sigen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int LEN_LSB = 0;
  localparam int SRC_LSB = 16;
  localparam int DST_LSB = 24;

  typedef struct packed {
    logic [15:0] pkt;     // packet index within the run
    logic [15:0] beat;    // beat index within the packet
    logic [1:0]  dst_sel; // pattern index mod 4
    logic        last;    // final beat of the packet
  } beat_desc_t;

endpackage

// File: rtl/axis_sigen_beat_fmt.sv
// Combinational beat formatter.
//   desc       : packet/beat/pattern indices and last flag
//   last_bytes : valid bytes on the last beat (already normalised to 1..BYTES)
//   byte_len   : total packet length in bytes
//   tdata      : {pkt, beat} replicated across the bus
//   tstrb      : all-ones, or low last_bytes bits on the last beat
//   tuser      : {zero, dst one-hot, src one-hot, byte length}
module axis_sigen_beat_fmt
  import axis_sigen_pkg::*;
#(
  parameter int TDATA_WIDTH = 256,
  parameter int TUSER_WIDTH = 128,
  parameter int LBW         = 6
) (
  input  beat_desc_t               desc,
  input  logic [LBW-1:0]           last_bytes,
  input  logic [15:0]              byte_len,
  output logic [TDATA_WIDTH-1:0]   tdata,
  output logic [TDATA_WIDTH/8-1:0] tstrb,
  output logic [TUSER_WIDTH-1:0]   tuser
);
  localparam int BYTES = TDATA_WIDTH / 8;

  always_comb begin
    tdata = {(TDATA_WIDTH/32){desc.pkt, desc.beat}};
    for (int i = 0; i < BYTES; i++)
      tstrb[i] = !desc.last || (i < int'(last_bytes));
    tuser = '0;
    tuser[LEN_LSB +: 16] = byte_len;
    tuser[SRC_LSB +: 8]  = 8'h01;
    tuser[DST_LSB +: 8]  = 8'h01 << {desc.dst_sel, 1'b0};
  end
endmodule

// File: rtl/axis_pkt_sigen.sv
// AXI4-Stream packet signal generator.
//   start / cfg_*           : run control; cfg is latched at start
//   tvalid..tlast / tready  : AXI4-Stream master, all outputs registered
//   busy / done / pkt_sent  : run status
// Output registers are loaded with the next beat whenever a new beat must be
// presented (start, accepted non-final beat, back-to-back packet, end of pause),
// so the first beat appears the cycle after start.
module axis_pkt_sigen
  import axis_sigen_pkg::*;
#(
  parameter int TDATA_WIDTH  = 256,
  parameter int TUSER_WIDTH  = 128,
  parameter int NUM_PATTERNS = 4,
  parameter int LEN_WIDTH    = 12,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [LEN_WIDTH-1:0]              cfg_pkt_beats,
  input  logic [$clog2(TDATA_WIDTH/8):0]    cfg_last_bytes,
  input  logic [LEN_WIDTH-1:0]              cfg_pause_cycles,
  input  logic [CNT_WIDTH-1:0]              cfg_num_pkts,
  output logic                              tvalid,
  input  logic                              tready,
  output logic [TDATA_WIDTH-1:0]            tdata,
  output logic [TDATA_WIDTH/8-1:0]          tstrb,
  output logic [TUSER_WIDTH-1:0]            tuser,
  output logic                              tlast,
  output logic                              busy,
  output logic                              done,
  output logic [CNT_WIDTH-1:0]              pkt_sent
);
  localparam int BYTES = TDATA_WIDTH / 8;
  localparam int LBW   = $clog2(BYTES) + 1;

  state_t               state;
  logic [LEN_WIDTH-1:0] beats_q, pause_q, beat_q, pause_cnt;
  logic [LBW-1:0]       lb_q;
  logic [CNT_WIDTH-1:0] num_q;
  logic [3:0]           pat_q;

  logic [LEN_WIDTH-1:0] beats_in, d_beats, nb;
  logic [LBW-1:0]       lb_in, d_lb;
  logic [CNT_WIDTH-1:0] pkt_inc;
  logic [3:0]           pat_inc;
  logic                 xfer, fin, load;
  logic [15:0]          byte_len;
  beat_desc_t           d;

  logic [TDATA_WIDTH-1:0]   f_data;
  logic [TDATA_WIDTH/8-1:0] f_strb;
  logic [TUSER_WIDTH-1:0]   f_user;

  // Normalised cfg used only on the start cycle (before it is latched).
  always_comb begin
    beats_in = (cfg_pkt_beats == '0) ? LEN_WIDTH'(1) : cfg_pkt_beats;
    lb_in    = (cfg_last_bytes == '0 || cfg_last_bytes > LBW'(BYTES)) ? LBW'(BYTES) : cfg_last_bytes;
  end

  assign xfer    = tvalid && tready;
  assign pkt_inc = pkt_sent + CNT_WIDTH'(1);
  assign pat_inc = (pat_q == 4'(NUM_PATTERNS - 1)) ? 4'd0 : pat_q + 4'd1;
  assign fin     = xfer && tlast && (num_q != '0) && (pkt_inc == num_q);
  assign nb      = beat_q + LEN_WIDTH'(1);

  // Select the descriptor of the beat to present next, if any.
  always_comb begin
    load    = 1'b0;
    d       = '0;
    d_beats = beats_q;
    d_lb    = lb_q;
    case (state)
      IDLE, DONE: if (start) begin
        load    = 1'b1;
        d_beats = beats_in;
        d_lb    = lb_in;
        d.last  = (beats_in == LEN_WIDTH'(1));
      end
      SEND: if (xfer) begin
        if (!tlast) begin
          load      = 1'b1;
          d.pkt     = 16'(pkt_sent);
          d.beat    = 16'(nb);
          d.dst_sel = pat_q[1:0];
          d.last    = (nb == beats_q - LEN_WIDTH'(1));
        end else if (!fin && pause_q == '0) begin
          load      = 1'b1;
          d.pkt     = 16'(pkt_inc);
          d.dst_sel = pat_inc[1:0];
          d.last    = (beats_q == LEN_WIDTH'(1));
        end
      end
      PAUSE: if (pause_cnt == LEN_WIDTH'(1)) begin
        load      = 1'b1;
        d.pkt     = 16'(pkt_sent);
        d.dst_sel = pat_q[1:0];
        d.last    = (beats_q == LEN_WIDTH'(1));
      end
      default: ;
    endcase
  end

  assign byte_len = (16'(d_beats) - 16'd1) * 16'(BYTES) + 16'(d_lb);

  axis_sigen_beat_fmt #(
    .TDATA_WIDTH (TDATA_WIDTH),
    .TUSER_WIDTH (TUSER_WIDTH),
    .LBW         (LBW)
  ) u_fmt (
    .desc       (d),
    .last_bytes (d_lb),
    .byte_len   (byte_len),
    .tdata      (f_data),
    .tstrb      (f_strb),
    .tuser      (f_user)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      beats_q   <= '0;
      pause_q   <= '0;
      beat_q    <= '0;
      pause_cnt <= '0;
      lb_q      <= '0;
      num_q     <= '0;
      pat_q     <= '0;
      tvalid    <= 1'b0;
      tdata     <= '0;
      tstrb     <= '0;
      tuser     <= '0;
      tlast     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pkt_sent  <= '0;
    end else begin
      if (load) begin
        tvalid <= 1'b1;
        tdata  <= f_data;
        tstrb  <= f_strb;
        tuser  <= f_user;
        tlast  <= d.last;
      end else if (xfer) begin
        tvalid <= 1'b0;
        tlast  <= 1'b0;
      end
      case (state)
        IDLE, DONE: if (start) begin
          beats_q  <= beats_in;
          lb_q     <= lb_in;
          pause_q  <= cfg_pause_cycles;
          num_q    <= cfg_num_pkts;
          pkt_sent <= '0;
          beat_q   <= '0;
          pat_q    <= '0;
          done     <= 1'b0;
          busy     <= 1'b1;
          state    <= SEND;
        end
        SEND: if (xfer) begin
          if (!tlast) begin
            beat_q <= nb;
          end else begin
            pkt_sent <= pkt_inc;
            pat_q    <= pat_inc;
            beat_q   <= '0;
            if (fin) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else if (pause_q != '0) begin
              pause_cnt <= pause_q;
              state     <= PAUSE;
            end
          end
        end
        PAUSE: begin
          if (pause_cnt == LEN_WIDTH'(1)) state <= SEND;
          else pause_cnt <= pause_cnt - LEN_WIDTH'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_pkt_sigen.sv
// Directed self-checking bench for axis_pkt_sigen (default parameters).
module tb_axis_pkt_sigen;
  logic         clk = 1'b0;
  logic         reset, start, tready;
  logic [11:0]  cfg_pkt_beats, cfg_pause_cycles;
  logic [5:0]   cfg_last_bytes;
  logic [15:0]  cfg_num_pkts;
  logic         tvalid, tlast, busy, done;
  logic [255:0] tdata;
  logic [31:0]  tstrb;
  logic [127:0] tuser;
  logic [15:0]  pkt_sent;

  int total = 0;
  int bad   = 0;

  axis_pkt_sigen dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_pkt_beats(cfg_pkt_beats), .cfg_last_bytes(cfg_last_bytes),
    .cfg_pause_cycles(cfg_pause_cycles), .cfg_num_pkts(cfg_num_pkts),
    .tvalid(tvalid), .tready(tready), .tdata(tdata), .tstrb(tstrb),
    .tuser(tuser), .tlast(tlast), .busy(busy), .done(done), .pkt_sent(pkt_sent)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int beats, input int lb, input int pause, input int num);
    cfg_pkt_beats    = 12'(beats);
    cfg_last_bytes   = 6'(lb);
    cfg_pause_cycles = 12'(pause);
    cfg_num_pkts     = 16'(num);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [255:0] exp_data(input int p, input int b);
    logic [15:0] p16, b16;
    p16 = 16'(p);
    b16 = 16'(b);
    return {8{p16, b16}};
  endfunction

  task automatic expect_beat(input string tag, input int p, input int b, input bit last,
                             input int lb, input int len, input int pat);
    logic [31:0]  es;
    logic [127:0] eu;
    logic [7:0]   dst;
    logic [15:0]  l16;
    l16 = 16'(len);
    dst = 8'h01 << (2 * (pat % 4));
    es  = !last ? 32'hFFFF_FFFF : (lb >= 32) ? 32'hFFFF_FFFF : (32'h1 << lb) - 32'h1;
    eu  = {96'h0, dst, 8'h01, l16};
    chk({tag, "_vld"},  tvalid, 1'b1);
    chk({tag, "_data"}, tdata, exp_data(p, b));
    chk({tag, "_strb"}, tstrb, es);
    chk({tag, "_user"}, tuser, eu);
    chk({tag, "_last"}, tlast, last);
  endtask

  // Walks a whole run with tready=1, starting on the negedge that shows beat 0.
  task automatic run_check(input string tag, input int beats, input int lb, input int pause,
                           input int num, input int len);
    for (int p = 0; p < num; p++) begin
      for (int b = 0; b < beats; b++) begin
        expect_beat(tag, p, b, b == beats - 1, lb, len, p % 4);
        chk({tag, "_busy"}, busy, 1'b1);
        @(negedge clk);
      end
      if (p != num - 1)
        for (int k = 0; k < pause; k++) begin
          chk({tag, "_idle"}, tvalid, 1'b0);
          @(negedge clk);
        end
    end
    chk({tag, "_end_vld"}, tvalid, 1'b0);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy0"}, busy, 1'b0);
    chk({tag, "_cnt"}, pkt_sent, 16'(num));
  endtask

  initial begin
    int ep, eb, nbeats;
    bit stalled, anybad;
    logic [255:0] hd;
    logic [127:0] hu;
    logic [31:0]  hs;
    logic         hl;

    reset = 1'b1; start = 1'b0; tready = 1'b1;
    cfg_pkt_beats = '0; cfg_last_bytes = '0; cfg_pause_cycles = '0; cfg_num_pkts = '0;
    repeat (3) @(negedge clk);
    chk("rst_vld", tvalid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cnt", pkt_sent, 16'd0);
    chk("rst_data", tdata, 256'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_vld", tvalid, 1'b0);

    // 2 packets x 4 beats, 8 bytes on last beat, 3-cycle pause: len = 3*32+8 = 104
    do_start(4, 8, 3, 2);
    run_check("t1", 4, 8, 3, 2, 104);

    // Single-beat back-to-back packets, beats=0 treated as 1, start from DONE; len = 4
    do_start(0, 4, 0, 5);
    run_check("t3", 1, 4, 0, 5, 4);

    // cfg changes right after start must not affect the run: len = 32+16 = 48
    do_start(2, 16, 2, 2);
    cfg_pkt_beats = 12'd5; cfg_last_bytes = 6'd1; cfg_pause_cycles = 12'd0; cfg_num_pkts = 16'd1;
    run_check("t5", 2, 16, 2, 2, 48);

    // Random backpressure: 3 packets x 3 beats, last_bytes=0 -> full strobe, len = 96
    ep = 0; eb = 0; nbeats = 0; stalled = 1'b0;
    hd = '0; hu = '0; hs = '0; hl = 1'b0;
    do_start(3, 0, 1, 3);
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (tvalid) begin
        if (stalled) begin
          chk("bp_hold_data", tdata, hd);
          chk("bp_hold_user", tuser, hu);
          chk("bp_hold_strb", tstrb, hs);
          chk("bp_hold_last", tlast, hl);
        end
        chk("bp_data", tdata, exp_data(ep, eb));
        chk("bp_last", tlast, eb == 2);
        chk("bp_strb", tstrb, 32'hFFFF_FFFF);
        chk("bp_user", tuser, {96'h0, 8'h01 << (2 * (ep % 4)), 8'h01, 16'd96});
        hd = tdata; hu = tuser; hs = tstrb; hl = tlast;
        tready = 1'($urandom_range(0, 1));
        stalled = !tready;
        if (tready) begin
          nbeats++;
          if (eb == 2) begin eb = 0; ep++; end
          else eb++;
        end
      end else begin
        tready = 1'($urandom_range(0, 1));
        stalled = 1'b0;
      end
      @(negedge clk);
    end
    tready = 1'b1;
    chk("bp_beats", nbeats, 9);
    chk("bp_done", done, 1'b1);
    chk("bp_cnt", pkt_sent, 16'd3);

    // Reset on beat 2 of 4: outputs drop before the next clock edge
    do_start(4, 8, 0, 0);
    expect_beat("rm_b0", 0, 0, 1'b0, 8, 104, 0);
    @(negedge clk);
    @(negedge clk);
    expect_beat("rm_b2", 0, 2, 1'b0, 8, 104, 0);
    #2 reset = 1'b1;
    #1;
    chk("rm_async_vld", tvalid, 1'b0);
    chk("rm_async_data", tdata, 256'd0);
    chk("rm_async_user", tuser, 128'd0);
    chk("rm_async_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rm_no_resume", tvalid, 1'b0);
    do_start(4, 8, 0, 1);
    run_check("rm_rs", 4, 8, 0, 1, 104);

    // Endless mode: 70000 single-beat packets, pkt_sent wraps at 65536
    anybad = 1'b0;
    do_start(1, 32, 0, 0);
    for (int i = 1; i <= 70000; i++) begin
      @(negedge clk);
      if (done || !busy || !tvalid) anybad = 1'b1;
      if (i == 65536) chk("end_wrap", pkt_sent, 16'd0);
    end
    chk("end_status", anybad, 1'b0);
    chk("end_cnt", pkt_sent, 16'd4464);
    chk("end_data", tdata, exp_data(4464, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axis_pkt_sigen.md
AXIS_PKT_SIGEN -- requirements
Module: axis_pkt_sigen

Interface
REQ-001 SHALL have parameter TDATA_WIDTH, default 256, AXI-stream data width in bits (multiple of 32).
REQ-002 SHALL have parameter TUSER_WIDTH, default 128, sideband width in bits (>= 32).
REQ-003 SHALL have parameter NUM_PATTERNS, default 4, number of rotating packet patterns (1..16).
REQ-004 SHALL have parameter LEN_WIDTH, default 12, width of the beat-count and pause-count inputs.
REQ-005 SHALL have parameter CNT_WIDTH, default 16, width of the packet counters.
REQ-006 SHALL have port clk, input, 1, sole clock.
REQ-007 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port start, input, 1, one-cycle pulse that begins a run; sampled only in IDLE or DONE.
REQ-009 SHALL have port cfg_pkt_beats, input, LEN_WIDTH, beats per packet; 0 is treated as 1.
REQ-010 SHALL have port cfg_last_bytes, input, log2(TDATA_WIDTH/8)+1, valid bytes in the last beat; 0 or above TDATA_WIDTH/8 is treated as TDATA_WIDTH/8.
REQ-011 SHALL have port cfg_pause_cycles, input, LEN_WIDTH, idle cycles between packets.
REQ-012 SHALL have port cfg_num_pkts, input, CNT_WIDTH, packets per run; 0 means run until reset.
REQ-013 SHALL have ports tvalid (output, 1), tready (input, 1), tdata (output, TDATA_WIDTH), tstrb (output, TDATA_WIDTH/8), tuser (output, TUSER_WIDTH) and tlast (output, 1), forming the AXI4-Stream master.
REQ-014 SHALL have ports busy (output, 1, run in progress), done (output, 1, run complete, held until next start) and pkt_sent (output, CNT_WIDTH, packets completed in the current run).

Function
REQ-015 SHALL implement the FSM states IDLE, SEND, PAUSE and DONE.
REQ-016 SHALL move IDLE/DONE->SEND on start, latch all cfg_* inputs, clear pkt_sent, beat index and pattern index, clear done and set busy.
REQ-017 SHALL treat cfg_* changes during a run as having no effect.
REQ-018 SHALL assert tvalid only in SEND, with tvalid, tdata, tstrb, tuser and tlast registered, and SHALL drive the first beat in the cycle after start.
REQ-019 SHALL hold every output stable while tvalid=1 and tready=0; a beat is transferred only when tvalid=1 and tready=1.
REQ-020 SHALL make tdata for beat b of packet p the 32-bit word {p[15:0], b[15:0]} replicated across TDATA_WIDTH.
REQ-021 SHALL drive tstrb all-ones except on the last beat, where exactly the low cfg_last_bytes bits are set.
REQ-022 SHALL make tuser[15:0] the byte length, (beats-1)*TDATA_WIDTH/8 + last_bytes.
REQ-023 SHALL make tuser[23:16] the source-port one-hot 8'h01 and tuser[31:24] the destination-port one-hot 8'h01 << (2*(pattern index mod 4)).
REQ-024 SHALL make tuser bits above 31 zero and hold tuser constant for the whole packet.
REQ-025 SHALL assert tlast on the final beat only; when beats=1, tlast SHALL be set on the first beat.
REQ-026 SHALL, on the tlast handshake, increment pkt_sent and advance the pattern index, wrapping NUM_PATTERNS-1 to 0.
REQ-027 SHALL, on the tlast handshake, go to DONE if pkt_sent+1 equals cfg_num_pkts (num_pkts not 0), else to PAUSE, or directly to SEND when cfg_pause_cycles=0.
REQ-028 SHALL stay in PAUSE for exactly cfg_pause_cycles cycles with tvalid=0, then go to SEND.
REQ-029 SHALL, in DONE, hold busy=0 and done=1; a start in the same cycle as DONE entry is ignored.
REQ-030 SHALL let pkt_sent wrap modulo 2^CNT_WIDTH in endless mode.

Reset
REQ-031 SHALL, while reset is asserted, force state IDLE and all outputs and counters to 0, asynchronously, with release synchronous to clk.
REQ-032 SHALL, on reset mid-packet, drop tvalid immediately; no resumption, and a new start is required.

Structure
REQ-033 SHALL place the state encoding and the tuser field offsets (LEN_LSB=0, SRC_LSB=16, DST_LSB=24) in the shared package axis_sigen_pkg.
REQ-034 SHALL use one sub-module, axis_sigen_beat_fmt, which combinationally forms tdata, tstrb and tuser from the packet index, beat index, pattern index and last flag.

Verification
REQ-035 SHALL test beats=4, last_bytes=8, pause=3, num=2 with tready=1: 8 beats, tstrb last=32'h000000FF, tuser[15:0]=104, 3 idle cycles between packets, then done=1.
REQ-036 SHALL test random tready backpressure (50%): every beat matches {p,b}, outputs stay stable while stalled, and there is no lost or duplicated beat.
REQ-037 SHALL test beats=1, pause=0, num=5: tlast on every beat, back-to-back packets, and destination ports cycling 01,04,10,40,01.
REQ-038 SHALL test reset asserted on beat 2 of 4: tvalid falls without waiting for clk, outputs are 0, and a subsequent start restarts at packet 0 beat 0.
REQ-039 SHALL test num=0 over 70000 packets: pkt_sent wraps to 0, done stays 0 and busy stays 1.
REQ-040 SHALL test a cfg change mid-run: the run completes using the latched values.
